// File: rtl/nwd_sterownik_if.sv
// Request/response bus of the GCD controller: operand request in, result out.
// The controller sits on the slave side; the requester/consumer uses master.
interface nwd_sterownik_if #(
    parameter int W = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_wynik;
    logic [15:0]  out_cykle;
    logic         out_timeout;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_wynik, out_cykle, out_timeout
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_wynik, out_cykle, out_timeout
    );
endinterface

// File: rtl/nwd_sterownik.sv
// Sequencer for an external GCD core: accepts one operand pair at a time,
// runs the core with a busy-cycle limit and holds the result until consumed.
module nwd_sterownik #(
    parameter int W       = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst,
    nwd_sterownik_if.slave bus,
    output logic [W-1:0] core_a,
    output logic [W-1:0] core_b,
    output logic         core_en,
    input  logic [W-1:0] core_wynik,
    input  logic         core_ready
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    localparam logic [16:0] LIMIT     = 17'(TIMEOUT);
    localparam logic [15:0] LIMIT_OUT = 16'(TIMEOUT);

    state_t       r_state;
    state_t       w_next;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic [W-1:0] r_wynik;
    logic [15:0]  r_cnt;
    logic [15:0]  r_cykle;
    logic         r_timeout;
    logic         w_limit;

    // Widened compare so TIMEOUT=65535 cannot wrap the counter comparison.
    assign w_limit = (({1'b0, r_cnt} + 17'd1) == LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid) w_next = LOAD;
            LOAD:    w_next = RUN;
            RUN:     if (core_ready || w_limit) w_next = DONE;
            DONE:    if (bus.out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // in_ready is gated by rst so it reads 0 while reset is held.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        core_en       = 1'b0;
        case (r_state)
            IDLE: bus.in_ready = ~rst;
            LOAD: core_en      = 1'b0;
            RUN:  core_en      = 1'b1;
            DONE: begin
                core_en       = 1'b1;
                bus.out_valid = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_cnt     <= '0;
            r_wynik   <= '0;
            r_cykle   <= '0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_a <= bus.in_a;
                        r_b <= bus.in_b;
                    end
                end
                LOAD: r_cnt <= '0;
                RUN: begin
                    if (!core_ready) begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                    // A core result in the limit cycle still wins over the timeout.
                    if (core_ready) begin
                        r_wynik   <= core_wynik;
                        r_cykle   <= r_cnt;
                        r_timeout <= 1'b0;
                    end else if (w_limit) begin
                        r_wynik   <= '0;
                        r_cykle   <= LIMIT_OUT;
                        r_timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign core_a          = r_a;
    assign core_b          = r_b;
    assign bus.out_wynik   = r_wynik;
    assign bus.out_cykle   = r_cykle;
    assign bus.out_timeout = r_timeout;

endmodule

// File: tb/tb_nwd_sterownik.sv
// Directed bench for nwd_sterownik with a GCD core model that raises
// core_ready k_cfg RUN cycles after core_en rises.
module tb_nwd_sterownik;

    logic        clk;
    logic        rst;
    logic [15:0] core_a;
    logic [15:0] core_b;
    logic        core_en;
    logic [15:0] core_wynik;
    logic        core_ready;

    int tests_run;
    int tests_failed;
    int k_cfg;
    int k_cnt;

    nwd_sterownik_if #(.W(16)) bus ();

    nwd_sterownik #(
        .W      (16),
        .TIMEOUT(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .core_a    (core_a),
        .core_b    (core_b),
        .core_en   (core_en),
        .core_wynik(core_wynik),
        .core_ready(core_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] gcd(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] t;
        x = a;
        y = b;
        for (int i = 0; i < 64; i++) begin
            if (y != 16'd0) begin
                t = x % y;
                x = y;
                y = t;
            end
        end
        return x;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst)           k_cnt <= 0;
        else if (!core_en) k_cnt <= 0;
        else               k_cnt <= k_cnt + 1;
    end

    assign core_ready = core_en && (k_cnt >= k_cfg);
    assign core_wynik = gcd(core_a, core_b);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (bus.out_valid === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        tests_run++; if (bus.in_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_in_ready got=%0d exp=0", bus.in_ready); end
        tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_out_valid got=%0d exp=0", bus.out_valid); end
        tests_run++; if (core_en !== 1'b0) begin tests_failed++; $display("FAIL rst_core_en got=%0d exp=0", core_en); end
        tests_run++; if (bus.out_timeout !== 1'b0) begin tests_failed++; $display("FAIL rst_timeout got=%0d exp=0", bus.out_timeout); end
        tests_run++; if ({bus.out_wynik, bus.out_cykle, core_a, core_b} !== 64'd0) begin tests_failed++; $display("FAIL rst_data got=%0h exp=0", {bus.out_wynik, bus.out_cykle, core_a, core_b}); end
        tick();
        tick();
        rst = 1'b0;
        tick();
        tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_release_in_ready got=%0d exp=1", bus.in_ready); end
    endtask

    task automatic test_basic();
        int n;
        k_cfg = 3;
        bus.out_ready = 1'b1;
        send(16'd12, 16'd18);
        tests_run++; if ({bus.in_ready, core_en} !== 2'b00) begin tests_failed++; $display("FAIL basic_load got=%b exp=00", {bus.in_ready, core_en}); end
        tests_run++; if ({core_a, core_b} !== {16'd12, 16'd18}) begin tests_failed++; $display("FAIL basic_core_ops got=%0d,%0d exp=12,18", core_a, core_b); end
        wait_valid(n);
        tests_run++; if (n !== 5) begin tests_failed++; $display("FAIL basic_latency got=%0d exp=5", n); end
        tests_run++; if (bus.out_wynik !== 16'd6) begin tests_failed++; $display("FAIL basic_wynik got=%0d exp=6", bus.out_wynik); end
        tests_run++; if (bus.out_cykle !== 16'd3) begin tests_failed++; $display("FAIL basic_cykle got=%0d exp=3", bus.out_cykle); end
        tests_run++; if (bus.out_timeout !== 1'b0) begin tests_failed++; $display("FAIL basic_timeout got=%0d exp=0", bus.out_timeout); end
        tick();
        tests_run++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin tests_failed++; $display("FAIL basic_one_pulse got=%b exp=01", {bus.out_valid, bus.in_ready}); end
    endtask

    task automatic test_latency();
        k_cfg = 0;
        bus.out_ready = 1'b1;
        send(16'd21, 16'd14);
        tests_run++; if ({core_en, bus.out_valid} !== 2'b00) begin tests_failed++; $display("FAIL lat_load got=%b exp=00", {core_en, bus.out_valid}); end
        tick();
        tests_run++; if ({core_en, bus.out_valid} !== 2'b10) begin tests_failed++; $display("FAIL lat_run got=%b exp=10", {core_en, bus.out_valid}); end
        tick();
        tests_run++; if (bus.out_valid !== 1'b1) begin tests_failed++; $display("FAIL lat_valid got=%0d exp=1", bus.out_valid); end
        tests_run++; if ({bus.out_wynik, bus.out_cykle} !== {16'd7, 16'd0}) begin tests_failed++; $display("FAIL lat_result got=%0d,%0d exp=7,0", bus.out_wynik, bus.out_cykle); end
        tick();
    endtask

    task automatic test_timeout();
        int n;
        k_cfg = 1000;
        bus.out_ready = 1'b1;
        send(16'd5, 16'd10);
        wait_valid(n);
        tests_run++; if (n !== 9) begin tests_failed++; $display("FAIL to_latency got=%0d exp=9", n); end
        tests_run++; if (bus.out_wynik !== 16'd0) begin tests_failed++; $display("FAIL to_wynik got=%0d exp=0", bus.out_wynik); end
        tests_run++; if (bus.out_cykle !== 16'd8) begin tests_failed++; $display("FAIL to_cykle got=%0d exp=8", bus.out_cykle); end
        tests_run++; if (bus.out_timeout !== 1'b1) begin tests_failed++; $display("FAIL to_flag got=%0d exp=1", bus.out_timeout); end
        tick();
        k_cfg = 7;
        send(16'd9, 16'd12);
        wait_valid(n);
        tests_run++; if (n !== 9) begin tests_failed++; $display("FAIL to_edge_latency got=%0d exp=9", n); end
        tests_run++; if ({bus.out_wynik, bus.out_cykle, bus.out_timeout} !== {16'd3, 16'd7, 1'b0}) begin tests_failed++; $display("FAIL to_edge_result got=%0d,%0d,%0d exp=3,7,0", bus.out_wynik, bus.out_cykle, bus.out_timeout); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_tab [4];
        exp_tab[0] = 3'b100;
        exp_tab[1] = 3'b000;
        exp_tab[2] = 3'b010;
        exp_tab[3] = 3'b011;
        k_cfg = 0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_a      = 16'd48;
        bus.in_b      = 16'd36;
        for (int i = 0; i < 12; i++) begin
            tests_run++; if ({bus.in_ready, core_en, bus.out_valid} !== exp_tab[i % 4]) begin tests_failed++; $display("FAIL b2b_cycle%0d got=%b exp=%b", i, {bus.in_ready, core_en, bus.out_valid}, exp_tab[i % 4]); end
            if (i % 4 == 3) begin
                tests_run++; if (bus.out_wynik !== 16'd12) begin tests_failed++; $display("FAIL b2b_wynik%0d got=%0d exp=12", i, bus.out_wynik); end
            end
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_stall();
        int n;
        k_cfg = 2;
        bus.out_ready = 1'b0;
        send(16'd20, 16'd8);
        wait_valid(n);
        tests_run++; if (n !== 4) begin tests_failed++; $display("FAIL stall_latency got=%0d exp=4", n); end
        for (int i = 0; i < 10; i++) begin
            tick();
            tests_run++; if ({bus.out_valid, bus.in_ready, bus.out_wynik, bus.out_cykle} !== {1'b1, 1'b0, 16'd4, 16'd2}) begin tests_failed++; $display("FAIL stall_hold%0d got=%0d,%0d,%0d,%0d exp=1,0,4,2", i, bus.out_valid, bus.in_ready, bus.out_wynik, bus.out_cykle); end
        end
        bus.in_valid  = 1'b1;
        bus.in_a      = 16'd9;
        bus.in_b      = 16'd6;
        bus.out_ready = 1'b1;
        tick();
        tests_run++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin tests_failed++; $display("FAIL done_exit_no_accept got=%b exp=01", {bus.out_valid, bus.in_ready}); end
        tick();
        bus.in_valid = 1'b0;
        tests_run++; if (bus.in_ready !== 1'b0) begin tests_failed++; $display("FAIL done_exit_next_accept got=%0d exp=0", bus.in_ready); end
        wait_valid(n);
        tests_run++; if ({n[7:0], bus.out_wynik} !== {8'd4, 16'd3}) begin tests_failed++; $display("FAIL done_exit_result got=%0d,%0d exp=4,3", n, bus.out_wynik); end
        tick();
    endtask

    task automatic test_zero();
        int n;
        k_cfg = 0;
        bus.out_ready = 1'b1;
        send(16'd0, 16'd15);
        tests_run++; if ({core_a, core_b} !== {16'd0, 16'd15}) begin tests_failed++; $display("FAIL zero_core_ops got=%0d,%0d exp=0,15", core_a, core_b); end
        wait_valid(n);
        tests_run++; if ({n[7:0], bus.out_wynik} !== {8'd2, 16'd15}) begin tests_failed++; $display("FAIL zero_result got=%0d,%0d exp=2,15", n, bus.out_wynik); end
        tick();
    endtask

    task automatic test_reset_mid_run();
        int n;
        int seen;
        k_cfg = 1000;
        bus.out_ready = 1'b1;
        send(16'd100, 16'd75);
        tick();
        tick();
        tests_run++; if (core_en !== 1'b1) begin tests_failed++; $display("FAIL mid_running got=%0d exp=1", core_en); end
        rst = 1'b1;
        #1;
        tests_run++; if ({bus.in_ready, bus.out_valid, core_en, bus.out_timeout} !== 4'b0000) begin tests_failed++; $display("FAIL mid_rst_ctrl got=%b exp=0000", {bus.in_ready, bus.out_valid, core_en, bus.out_timeout}); end
        tests_run++; if ({bus.out_wynik, bus.out_cykle, core_a, core_b} !== 64'd0) begin tests_failed++; $display("FAIL mid_rst_data got=%0h exp=0", {bus.out_wynik, bus.out_cykle, core_a, core_b}); end
        tick();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.out_valid === 1'b1) seen++;
        end
        tests_run++; if (seen !== 0) begin tests_failed++; $display("FAIL mid_no_result got=%0d exp=0", seen); end
        k_cfg = 1;
        send(16'd35, 16'd21);
        wait_valid(n);
        tests_run++; if ({n[7:0], bus.out_wynik, bus.out_timeout} !== {8'd3, 16'd7, 1'b0}) begin tests_failed++; $display("FAIL mid_after_result got=%0d,%0d,%0d exp=3,7,0", n, bus.out_wynik, bus.out_timeout); end
        tick();
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        k_cfg         = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_latency();
        test_timeout();
        test_back_to_back();
        test_stall();
        test_zero();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/nwd_sterownik.md
NWD_STEROWNIK -- requirements
Module: nwd_sterownik

Interface
REQ-001 Parameter W, default 16, SHALL set the operand and result width.
REQ-002 Parameter TIMEOUT, default 1024, range 1..65535, SHALL set the maximum core busy cycles per operation.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 in_valid  in  1  request pair valid.
REQ-006 in_ready  out  1  block accepts a request this cycle.
REQ-007 in_a, in_b  in  W each  operands.
REQ-008 out_valid  out  1  result valid.
REQ-009 out_ready  in  1  consumer accepts the result.
REQ-010 out_wynik  out  W  GCD result.
REQ-011 out_cykle  out  16  core busy-cycle count for this result.
REQ-012 out_timeout  out  1  result aborted by timeout.
REQ-013 core_a, core_b  out  W each  operands driven to the GCD core.
REQ-014 core_en  out  1  core enable; low = core loads operands, high = core computes.
REQ-015 core_wynik  in  W  core result.
REQ-016 core_ready  in  1  core result valid; meaningful only while core_en=1.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, LOAD, RUN, DONE.
REQ-018 IDLE: in_ready=1, core_en=0; on in_valid=1, latch in_a/in_b into operand registers and go to LOAD.
REQ-019 in_ready SHALL be 1 only in IDLE, so only one request is in flight.
REQ-020 LOAD: core_en=0 for exactly one cycle; clear busy counter; go to RUN.
REQ-021 core_a/core_b SHALL drive the latched operands continuously from LOAD until the next accept.
REQ-022 RUN: core_en=1; each cycle with core_ready=0, busy counter +1.
REQ-023 RUN with core_ready=1: latch core_wynik into out_wynik, counter into out_cykle, out_timeout=0, go to DONE.
REQ-024 RUN with core_ready=0 and counter+1 = TIMEOUT: out_wynik=0, out_cykle=TIMEOUT, out_timeout=1, go to DONE.
REQ-025 If both conditions hold in one cycle, core_ready SHALL take priority.
REQ-026 DONE: out_valid=1, core_en held 1, outputs stable; on out_ready=1 go to IDLE.
REQ-027 out_valid SHALL be 1 only in DONE; out_ready outside DONE has no effect.
REQ-028 A new request SHALL NOT be accepted in the cycle DONE exits; the earliest next accept is the following cycle.
REQ-029 Best-case latency: accept edge T, LOAD T+1, first RUN cycle T+2; with core_ready=1 there, out_valid=1 from T+3 and out_cykle=0.
REQ-030 Zero operands SHALL be passed to the core unchanged; the core result is reported as-is.

Reset
REQ-031 rst=1 SHALL immediately force IDLE, independent of clk.
REQ-032 During rst=1: in_ready=0, out_valid=0, core_en=0, out_timeout=0.
REQ-033 During rst=1: out_wynik, out_cykle, core_a, core_b, counter all 0.
REQ-034 Reset SHALL abort any in-flight operation without producing a result.
REQ-035 After rst falls, in_ready SHALL be 1 from the first clk edge.

Verification (bench uses a core model raising core_ready K RUN cycles after core_en rises)
REQ-036 in_a=12, in_b=18, K=3, out_ready=1 -> one out_valid pulse; out_wynik=6, out_cykle=3, out_timeout=0.
REQ-037 TIMEOUT=8, core_ready never rises -> out_valid after 8 RUN cycles; out_wynik=0, out_cykle=8, out_timeout=1.
REQ-038 K=0, requests back-to-back, out_ready=1 -> accepts at most every 4 cycles; core_en low exactly one cycle before each RUN.
REQ-039 out_ready=0 for 10 cycles in DONE -> out_valid, out_wynik, out_cykle stable; in_ready=0 throughout.
REQ-040 rst pulsed mid-RUN -> all outputs 0 immediately, no out_valid; a following request (35,21) -> out_wynik=7.
